uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receive stage, 8N1, LSB first, fixed baud set by CLK_PER_BIT.
//  Oversamples the asynchronous rx pin and samples each bit at its midpoint.
//  Every good frame produces one recv_data byte with a one-cycle recv_ok strobe.
//  Sits directly upstream of the UART controller, which buffers these bytes for the core.
// PARAMETERS
//  CLK_PER_BIT  868  clock cycles per bit (100 MHz / 115200); legal range >= 4; H = CLK_PER_BIT/2 (floor)
// PORTS
//  clk          in   1  system clock; all state on rising edge
//  reset        in   1  asynchronous, active-low reset
//  rx           in   1  serial line, asynchronous to clk, idle high
//  recv_data    out  8  last correctly received byte
//  recv_ok      out  1  one-cycle strobe: recv_data updated this cycle
//  frame_error  out  1  one-cycle strobe: stop bit sampled low, byte discarded
//  busy         out  1  high whenever state != IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, counters=0, shift reg=0, both sync flops=1.
//   recv_data=8'h00, recv_ok=0, frame_error=0, busy=0. Takes effect mid-frame too:
//   partial byte dropped, no strobe. After release, a new frame is accepted only from a
//   fresh falling edge.
//  Sync: 2-flop synchronizer on rx; rx_s = second flop. FSM uses only rx_s.
//  Counters: cnt is $clog2(CLK_PER_BIT) bits, counts down to 0; bit_idx is 3 bits.
//  FSM:
//   IDLE:   rx_s==0 -> START, cnt=H-1.
//   START:  cnt!=0 -> decrement. At cnt==0 (mid start bit): rx_s==0 -> DATA, cnt=CLK_PER_BIT-1,
//           bit_idx=0. rx_s==1 -> glitch, back to IDLE, no strobe.
//   DATA:   at cnt==0: shift rx_s in at MSB (shreg={rx_s,shreg[7:1]}), cnt=CLK_PER_BIT-1.
//           bit_idx==7 -> STOP, else bit_idx+1.
//   STOP:   at cnt==0: rx_s==1 -> recv_data=shreg, recv_ok=1, go to IDLE.
//           rx_s==0 -> frame_error=1, recv_data unchanged, go to BREAK.
//   BREAK:  wait for rx_s==1, then go to IDLE. A held-low line (break) yields exactly one frame_error.
//  Timing: E0 = first edge sampling rx low; rx_s low after E1; IDLE leaves at E2.
//   Data bit i is sampled at E2+H+(i+1)*CLK_PER_BIT.
//   The stop bit is sampled at E2+H+9*CLK_PER_BIT.
//   recv_ok/frame_error are high exactly in the cycle after that edge.
//  Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge immediately after
//   the stop bit is caught. No gap is required between frames.
//  recv_ok and frame_error are never high together. Each is never high for 2 consecutive cycles.
//  There is no backpressure: the consumer must take each byte on its recv_ok strobe.
//  recv_data is stable between strobes.
//  Baud tolerance: sampling at mid-bit allows up to about +/-4% clock mismatch per frame.
// TESTING (CLK_PER_BIT=16 unless noted; bench drives rx with exact 16-cycle bits)
//  1. Reset held low with rx toggling -> all outputs 0, busy 0. Release, line idle 50 cycles
//     -> no strobes.
//  2. Send 8'hA5 -> exactly one recv_ok, at E2+8+144; recv_data=8'hA5; busy falls in the same
//     cycle; frame_error never high.
//  3. Send 8'h00, 8'hFF, 8'h53 back-to-back with no idle gap -> three recv_ok strobes, 160 cycles
//     apart, with data 00/FF/53.
//  4. rx low for 5 cycles, then high -> START aborts, busy drops, no recv_ok or frame_error.
//     Next 8'h3C is received correctly.
//  5. Frame 8'h81 with stop bit low, rx held low 100 more cycles -> one frame_error, recv_data
//     keeps its previous value. After rx high, 8'h7E is received OK.
//  6. Drive reset low mid-DATA of 8'hC3 -> outputs clear immediately. Release, then send 8'h12
//     -> recv_data=8'h12. Repeat tests 2-3 with CLK_PER_BIT=5 (odd, H=2).

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage, LSB first, fixed baud of CLK_PER_BIT clocks per bit.
// The rx pin is brought into the clock domain by a two-flop synchronizer. Each bit is
// sampled once, at its midpoint, measured from the detected start edge. A good frame
// produces a one-cycle recv_ok strobe. A low stop bit produces a one-cycle frame_error
// strobe, and the byte is discarded.
module uart_receiver #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] recv_data,
    output logic       recv_ok,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    // Reload values: half a bit to reach mid start bit, then one full bit per sample.
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          rx_s;

    state_t        state_q,       state_d;
    logic [CW-1:0] cnt_q,         cnt_d;
    logic [2:0]    bit_idx_q,     bit_idx_d;
    logic [7:0]    shreg_q,       shreg_d;
    logic [7:0]    recv_data_q,   recv_data_d;
    logic          recv_ok_q,     recv_ok_d;
    logic          frame_error_q, frame_error_d;
    logic          busy_q,        busy_d;

    // Two-flop synchronizer. It resets to the idle-high line level so that a fresh
    // falling edge is needed before a frame can start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // FSM, counter, shift register and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= CNT_ZERO;
            bit_idx_q     <= 3'd0;
            shreg_q       <= 8'h00;
            recv_data_q   <= 8'h00;
            recv_ok_q     <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            recv_data_q   <= recv_data_d;
            recv_ok_q     <= recv_ok_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state logic. Strobes default low, so each one lasts exactly one cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        recv_data_d   = recv_data_q;
        recv_ok_d     = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = HALF_M1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!rx_s) begin
                    state_d   = ST_DATA;
                    cnt_d     = FULL_M1;
                    bit_idx_d = 3'd0;
                end else begin
                    // The line went back high before mid start bit: treat it as a glitch.
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = ST_STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (rx_s) begin
                    // Leave at mid stop bit so that a back-to-back start edge is caught.
                    recv_data_d = shreg_q;
                    recv_ok_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    frame_error_d = 1'b1;
                    state_d       = ST_BREAK;
                end
            end
            ST_BREAK: begin
                // Park here while the line is held low, so a break gives exactly one error.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign recv_data   = recv_data_q;
    assign recv_ok     = recv_ok_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule
